// File: rtl/otter_icache_pkg.sv
// Shared definitions for the instruction cache and its refill controller.
// Holds the controller state encoding and the helpers that derive the
// address-field widths from the cache geometry (LINES lines of WORDS words).
package otter_icache_pkg;

  typedef enum logic [1:0] {
    IDLE,   // serving fetches, detecting misses
    FILL,   // pulling one line from memory, one word per ack
    CLEAR   // walking every line and dropping its valid bit
  } state_e;

  localparam int ADDR_W = 32;

  // Word-within-line field width.
  function automatic int offset_w(input int words);
    return $clog2(words);
  endfunction

  // Line-select field width.
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Everything above offset, index and the two byte-select bits.
  function automatic int tag_w(input int lines, input int words);
    return ADDR_W - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Valid bits and tags for a direct-mapped cache.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears all valid bits)
//   rd_index, rd_tag      lookup address fields
//   hit                   rd line is valid and its tag equals rd_tag
//   wr_en, wr_index,
//   wr_tag, wr_valid      single-line write of tag and valid bit
//   clr_en, clr_index     drop the valid bit of one line (bulk clear walk)
module icache_tag_store
  import otter_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 21
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [index_w(LINES)-1:0]  rd_index,
  input  logic [TAG_W-1:0]           rd_tag,
  output logic                       hit,
  input  logic                       wr_en,
  input  logic [index_w(LINES)-1:0]  wr_index,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic                       wr_valid,
  input  logic                       clr_en,
  input  logic [index_w(LINES)-1:0]  clr_index
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];

  // NOTE: every variable assigned here gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_index] = 1'b0;
    if (wr_en)  valid_d[wr_index]  = wr_valid;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: the tag array is not reset; a line is only trusted through its
  // valid bit, which is reset, so resetting the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_index] <= wr_tag;
  end

  assign hit = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with miss refill and whole-cache invalidate.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   rd_en, addr      fetch request and byte address (bits [1:0] ignored)
//   invalidate       one-cycle pulse: clear every valid bit (fence.i)
//   instr            fetched word; zero unless rd_en and not stalled
//   stall            fetch cannot complete this cycle (combinational)
//   mem_req,
//   mem_addr         registered refill word request and byte address
//   mem_ack,
//   mem_rdata        memory returns the word for mem_addr this cycle
module icache_refill_ctrl
  import otter_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OB = offset_w(WORDS);
  localparam int IB = index_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);
  localparam int LW = ADDR_W - 2 - OB;  // line address: {tag, index}
  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS - 1);
  localparam logic [IB-1:0] LAST_LINE = IB'(LINES - 1);

  // Address split of the current fetch.
  logic [OB-1:0] offset;
  logic [IB-1:0] index;
  logic [TW-1:0] tag;
  logic [1:0]    unused_byte_sel;
  assign offset          = addr[OB+1:2];
  assign index           = addr[OB+IB+1:OB+2];
  assign tag             = addr[31:OB+IB+2];
  assign unused_byte_sel = addr[1:0];

  state_e        state_q, state_d;
  logic [LW-1:0] line_q, line_d;          // line being refilled
  logic [OB-1:0] word_cnt_q, word_cnt_d;
  logic [IB-1:0] line_cnt_q, line_cnt_d;
  logic          pend_q, pend_d;          // invalidate seen during a fill
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;

  logic [31:0] data_q [LINES][WORDS];
  logic        data_we;

  logic          tag_hit;
  logic          ts_wr_en, ts_wr_valid, ts_clr_en;
  logic [IB-1:0] ts_wr_index;

  icache_tag_store #(
    .LINES (LINES),
    .TAG_W (TW)
  ) u_tag_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (index),
    .rd_tag    (tag),
    .hit       (tag_hit),
    .wr_en     (ts_wr_en),
    .wr_index  (ts_wr_index),
    .wr_tag    (line_q[LW-1:IB]),
    .wr_valid  (ts_wr_valid),
    .clr_en    (ts_clr_en),
    .clr_index (line_cnt_q)
  );

  // Fetch completes only from IDLE on a hit; an idle cycle with no request
  // never stalls.
  always_comb begin
    stall = (state_q != IDLE) || (rd_en && !tag_hit);
    instr = (rd_en && !stall) ? data_q[index][offset] : '0;
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    word_cnt_d  = word_cnt_q;
    line_cnt_d  = line_cnt_q;
    pend_d      = pend_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ts_wr_en    = 1'b0;
    ts_wr_index = line_q[IB-1:0];
    ts_wr_valid = 1'b0;
    ts_clr_en   = 1'b0;
    data_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (invalidate) begin
          state_d    = CLEAR;
          line_cnt_d = '0;
        end else if (rd_en && !tag_hit) begin
          // The victim line is invalid from here until its last word lands,
          // so an interrupted refill can never produce a hit.
          line_d      = addr[31:OB+2];
          ts_wr_en    = 1'b1;
          ts_wr_index = index;
          word_cnt_d  = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = {addr[31:OB+2], {(OB+2){1'b0}}};
          state_d     = FILL;
        end
      end

      FILL: begin
        // Memory cannot cancel a request, so an invalidate only queues.
        if (invalidate) pend_d = 1'b1;
        if (mem_ack) begin
          data_we = 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            ts_wr_en    = 1'b1;
            ts_wr_valid = 1'b1;
            mem_req_d   = 1'b0;
            word_cnt_d  = '0;
            if (pend_q || invalidate) begin
              state_d    = CLEAR;
              line_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            word_cnt_d = word_cnt_q + OB'(1);
            mem_addr_d = {line_q, word_cnt_q + OB'(1), 2'b00};
          end
        end
      end

      CLEAR: begin
        // A further invalidate here is absorbed: the walk already covers it.
        ts_clr_en = 1'b1;
        if (line_cnt_q == LAST_LINE) begin
          line_cnt_d = '0;
          pend_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          line_cnt_d = line_cnt_q + IB'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
      pend_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
      pend_q     <= pend_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[line_q[IB-1:0]][word_cnt_q] <= mem_rdata;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule
